// File: rtl/winker_pkg.sv
// Shared encodings for the winker lamp monitor: FSM states, direction and fault codes.
package winker_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LEFT   = 3'd1;
    localparam logic [ST_W-1:0] ST_RIGHT  = 3'd2;
    localparam logic [ST_W-1:0] ST_HAZARD = 3'd3;
    localparam logic [ST_W-1:0] ST_FAULT  = 3'd4;

    localparam logic [1:0] DIR_NONE   = 2'b00;
    localparam logic [1:0] DIR_LEFT   = 2'b01;
    localparam logic [1:0] DIR_RIGHT  = 2'b10;
    localparam logic [1:0] DIR_HAZARD = 2'b11;

    localparam logic [1:0] FLT_NONE  = 2'd0;
    localparam logic [1:0] FLT_FAST  = 2'd1;
    localparam logic [1:0] FLT_STUCK = 2'd2;
    localparam logic [1:0] FLT_CROSS = 2'd3;

    // Direction reported on the dashboard for a given FSM state.
    function automatic logic [1:0] state_dir(input logic [ST_W-1:0] st);
        logic [1:0] d;
        d = DIR_NONE;
        case (st)
            ST_LEFT:   d = DIR_LEFT;
            ST_RIGHT:  d = DIR_RIGHT;
            ST_HAZARD: d = DIR_HAZARD;
            default:   d = DIR_NONE;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/winker_lamp_sync.sv
// Two-flop synchronizer for one asynchronous lamp line plus edge detection.
module winker_lamp_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic lamp,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    // Metastability stages followed by the previous-value register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= lamp;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level  = sync;
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/winker_lamp_monitor.sv
// Receive-side monitor for the turn-signal lamps: direction decode, flash count, timing faults.
module winker_lamp_monitor
    import winker_pkg::*;
#(
    parameter int unsigned FLASH_W      = 8,
    parameter int unsigned MIN_HALF     = 4,
    parameter int unsigned MAX_HALF     = 64,
    parameter int unsigned IDLE_TIMEOUT = 128,
    parameter int unsigned SKEW_MAX     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_left_lamp,
    input  logic               i_right_lamp,
    input  logic               i_clear,
    output logic               o_idle,
    output logic [1:0]         o_dir,
    output logic               o_flash_pulse,
    output logic [FLASH_W-1:0] o_flash_cnt,
    output logic               o_fault,
    output logic [1:0]         o_fault_code
);

    localparam int unsigned PH_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned SK_W = $clog2(SKEW_MAX + 2);

    localparam logic [PH_W-1:0]    PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]    PH_MIN   = PH_W'(MIN_HALF);
    localparam logic [PH_W-1:0]    PH_STUCK = PH_W'(MAX_HALF + 1);
    localparam logic [PH_W-1:0]    PH_TO    = PH_W'(IDLE_TIMEOUT);
    localparam logic [SK_W-1:0]    SK_ONE   = SK_W'(1);
    localparam logic [SK_W-1:0]    SK_LIM   = SK_W'(SKEW_MAX);
    localparam logic [SK_W-1:0]    SK_SAT   = SK_W'(SKEW_MAX + 1);
    localparam logic [FLASH_W-1:0] FL_ONE   = FLASH_W'(1);

    logic left_lvl, left_rise, left_fall;
    logic right_lvl, right_rise, right_fall;

    logic [ST_W-1:0]    state, state_nxt;
    logic [PH_W-1:0]    phase_cnt, phase_nxt;
    logic [SK_W-1:0]    skew_cnt, skew_nxt;
    logic [FLASH_W-1:0] flash_nxt, flash_inc;
    logic [1:0]         code_nxt;
    logic               pulse_nxt;

    logic trk_lvl, trk_rise, trk_fall, trk_edge, opp_rise, phase_hi;
    logic f_cross, f_stuck, f_fast, timeout;

    winker_lamp_sync u_sync_left (
        .clk    (clk),
        .reset_n(reset_n),
        .lamp   (i_left_lamp),
        .level  (left_lvl),
        .rise_c (left_rise),
        .fall_c (left_fall)
    );

    winker_lamp_sync u_sync_right (
        .clk    (clk),
        .reset_n(reset_n),
        .lamp   (i_right_lamp),
        .level  (right_lvl),
        .rise_c (right_rise),
        .fall_c (right_fall)
    );

    // Next-state, counter and fault decode.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_cnt;
        skew_nxt  = '0;
        flash_nxt = o_flash_cnt;
        code_nxt  = o_fault_code;
        pulse_nxt = 1'b0;
        f_cross   = 1'b0;
        f_stuck   = 1'b0;
        f_fast    = 1'b0;
        timeout   = 1'b0;

        // RIGHT tracks the right lamp; LEFT and HAZARD track the left lamp.
        trk_lvl  = (state == ST_RIGHT) ? right_lvl  : left_lvl;
        trk_rise = (state == ST_RIGHT) ? right_rise : left_rise;
        trk_fall = (state == ST_RIGHT) ? right_fall : left_fall;
        opp_rise = (state == ST_RIGHT) ? left_rise  : right_rise;
        trk_edge = trk_rise | trk_fall;
        // Level of the phase the counter is measuring (the one just ending on an edge).
        phase_hi = trk_edge ? ~trk_lvl : trk_lvl;

        flash_inc = (o_flash_cnt == '1) ? o_flash_cnt : o_flash_cnt + FL_ONE;

        case (state)
            ST_IDLE: begin
                phase_nxt = '0;
                if (left_rise || right_rise) begin
                    if (left_rise && right_rise) state_nxt = ST_HAZARD;
                    else if (left_rise)          state_nxt = ST_LEFT;
                    else                         state_nxt = ST_RIGHT;
                    phase_nxt = PH_ONE;
                    flash_nxt = FL_ONE;
                    pulse_nxt = 1'b1;
                end
            end

            ST_LEFT, ST_RIGHT, ST_HAZARD: begin
                if (trk_edge)                phase_nxt = PH_ONE;
                else if (phase_cnt != PH_TO) phase_nxt = phase_cnt + PH_ONE;

                f_fast  = trk_edge && (phase_cnt < PH_MIN);
                f_stuck = phase_hi && (phase_cnt >= PH_STUCK);

                if (state == ST_HAZARD) begin
                    if (left_lvl != right_lvl) begin
                        skew_nxt = (skew_cnt == SK_SAT) ? skew_cnt : skew_cnt + SK_ONE;
                        f_cross  = (skew_cnt >= SK_LIM);
                    end
                    timeout = !trk_edge && !phase_hi && !right_lvl && (phase_cnt >= PH_TO);
                end else begin
                    f_cross = opp_rise && trk_lvl;
                    timeout = !trk_edge && !phase_hi && (phase_cnt >= PH_TO);
                end

                if (f_cross || f_stuck || f_fast) begin
                    state_nxt = ST_FAULT;
                    phase_nxt = '0;
                    skew_nxt  = '0;
                    if (f_cross)      code_nxt = FLT_CROSS;
                    else if (f_stuck) code_nxt = FLT_STUCK;
                    else              code_nxt = FLT_FAST;
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                    skew_nxt  = '0;
                end else if ((state != ST_HAZARD) && opp_rise) begin
                    // Driver switched direction while the tracked lamp was dark.
                    state_nxt = (state == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                    phase_nxt = PH_ONE;
                    flash_nxt = FL_ONE;
                    pulse_nxt = 1'b1;
                end else if (trk_rise) begin
                    flash_nxt = flash_inc;
                    pulse_nxt = 1'b1;
                end
            end

            ST_FAULT: begin
                phase_nxt = '0;
            end

            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end
        endcase

        // Clear overrides any fault or rise seen in the same cycle.
        if (i_clear) begin
            state_nxt = ST_IDLE;
            phase_nxt = '0;
            skew_nxt  = '0;
            flash_nxt = '0;
            code_nxt  = FLT_NONE;
            pulse_nxt = 1'b0;
        end
    end

    // State, counters and registered dashboard outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            phase_cnt     <= '0;
            skew_cnt      <= '0;
            o_flash_cnt   <= '0;
            o_fault_code  <= FLT_NONE;
            o_flash_pulse <= 1'b0;
            o_idle        <= 1'b1;
            o_dir         <= DIR_NONE;
            o_fault       <= 1'b0;
        end else begin
            state         <= state_nxt;
            phase_cnt     <= phase_nxt;
            skew_cnt      <= skew_nxt;
            o_flash_cnt   <= flash_nxt;
            o_fault_code  <= code_nxt;
            o_flash_pulse <= pulse_nxt;
            o_idle        <= (state_nxt == ST_IDLE);
            o_dir         <= state_dir(state_nxt);
            o_fault       <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_winker_lamp_monitor.sv
// Scoreboard bench for winker_lamp_monitor: expected output events are queued with stimulus
// and a monitor compares every observed output change or flash pulse in order.
module tb_winker_lamp_monitor;

    typedef struct packed {
        logic       idle;
        logic [1:0] dir;
        logic       pulse;
        logic [7:0] cnt;
        logic       fault;
        logic [1:0] code;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
        int    gmin;
        int    gmax;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       left_lamp;
    logic       right_lamp;
    logic       clear;
    logic       o_idle;
    logic [1:0] o_dir;
    logic       o_flash_pulse;
    logic [7:0] o_flash_cnt;
    logic       o_fault;
    logic [1:0] o_fault_code;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    winker_lamp_monitor #(
        .FLASH_W     (8),
        .MIN_HALF    (4),
        .MAX_HALF    (64),
        .IDLE_TIMEOUT(128),
        .SKEW_MAX    (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_left_lamp  (left_lamp),
        .i_right_lamp (right_lamp),
        .i_clear      (clear),
        .o_idle       (o_idle),
        .o_dir        (o_dir),
        .o_flash_pulse(o_flash_pulse),
        .o_flash_cnt  (o_flash_cnt),
        .o_fault      (o_fault),
        .o_fault_code (o_fault_code)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then step off the edge before driving.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    // Queue one expected output event; gmax==0 disables the spacing check.
    task automatic push(input string name, input logic idle, input logic [1:0] dir,
                        input logic pulse, input int cnt, input logic fault,
                        input logic [1:0] code, input int gmin, input int gmax);
        exp_t e;
        e.name    = name;
        e.s.idle  = idle;
        e.s.dir   = dir;
        e.s.pulse = pulse;
        e.s.cnt   = 8'(cnt);
        e.s.fault = fault;
        e.s.code  = code;
        e.gmin    = gmin;
        e.gmax    = gmax;
        exp_q.push_back(e);
    endtask

    // Monitor: an event is a flash pulse or any change of the other outputs.
    initial begin
        snap_t cur;
        snap_t last;
        exp_t  e;
        bit    first;
        int    cyc;
        int    last_cyc;
        first    = 1'b1;
        cyc      = 0;
        last_cyc = 0;
        last     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur.idle  = o_idle;
            cur.dir   = o_dir;
            cur.pulse = o_flash_pulse;
            cur.cnt   = o_flash_cnt;
            cur.fault = o_fault;
            cur.code  = o_fault_code;
            if (first || cur.pulse ||
                ({cur.idle, cur.dir, cur.cnt, cur.fault, cur.code} !=
                 {last.idle, last.dir, last.cnt, last.fault, last.code})) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got idle=%0b dir=%0d pulse=%0b cnt=%0d fault=%0b code=%0d, want no event (cycle %0d)",
                             cur.idle, cur.dir, cur.pulse, cur.cnt, cur.fault, cur.code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e.s) begin
                        errors++;
                        $display("FAIL %s: got idle=%0b dir=%0d pulse=%0b cnt=%0d fault=%0b code=%0d, want idle=%0b dir=%0d pulse=%0b cnt=%0d fault=%0b code=%0d",
                                 e.name, cur.idle, cur.dir, cur.pulse, cur.cnt, cur.fault, cur.code,
                                 e.s.idle, e.s.dir, e.s.pulse, e.s.cnt, e.s.fault, e.s.code);
                    end
                    if (e.gmax != 0) begin
                        checks++;
                        if ((cyc - last_cyc) < e.gmin || (cyc - last_cyc) > e.gmax) begin
                            errors++;
                            $display("FAIL %s_gap: got %0d cycles since previous event, want %0d..%0d",
                                     e.name, cyc - last_cyc, e.gmin, e.gmax);
                        end
                    end
                end
                last_cyc = cyc;
                first    = 1'b0;
            end
            last = cur;
        end
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 ns, want stimulus finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        left_lamp  = 1'b0;
        right_lamp = 1'b0;
        clear      = 1'b0;
        reset_n    = 1'b1;
        push("reset_state", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        #1 reset_n = 1'b0;
        tick(4);
        reset_n = 1'b1;
        tick(4);

        // Reset in the middle of a left sequence, lamps toggling during reset.
        push("t1_rise1", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t1_rise2", 1'b0, 2'b01, 1'b1, 2, 1'b0, 2'd0, 32, 32);
        push("t1_reset", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        left_lamp = 1'b1; tick(16);
        left_lamp = 1'b0; tick(16);
        left_lamp = 1'b1; tick(8);
        reset_n = 1'b0; tick(3);
        left_lamp = 1'b0; tick(3);
        left_lamp = 1'b1; right_lamp = 1'b1; tick(4);
        left_lamp = 1'b0; right_lamp = 1'b0; tick(5);
        reset_n = 1'b1; tick(6);

        // Five legal left flashes, then timeout back to idle holding the count.
        push("t2_rise1", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        for (int i = 2; i <= 5; i++)
            push($sformatf("t2_rise%0d", i), 1'b0, 2'b01, 1'b1, i, 1'b0, 2'd0, 32, 32);
        push("t2_idle_timeout", 1'b1, 2'b00, 1'b0, 5, 1'b0, 2'd0, 143, 145);
        for (int i = 0; i < 5; i++) begin
            left_lamp = 1'b1; tick(16);
            left_lamp = 1'b0; tick(16);
        end
        tick(150);

        // Fast flashing trips FAST on the first fall; activity ignored until clear.
        push("t3_rise", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t3_fast", 1'b0, 2'b00, 1'b0, 1, 1'b1, 2'd1, 2, 2);
        push("t3_clear", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            left_lamp = 1'b1; tick(2);
            left_lamp = 1'b0; tick(2);
        end
        tick(6);
        clear_pulse();
        tick(4);

        // Right lamp stuck on.
        push("t4_rise", 1'b0, 2'b10, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t4_stuck", 1'b0, 2'b00, 1'b0, 1, 1'b1, 2'd2, 64, 66);
        push("t4_clear", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        right_lamp = 1'b1; tick(100);
        right_lamp = 1'b0; tick(6);
        clear_pulse();
        tick(4);

        // Hazard in phase, then right stays dark while left keeps flashing.
        push("t5_rise1", 1'b0, 2'b11, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t5_rise2", 1'b0, 2'b11, 1'b1, 2, 1'b0, 2'd0, 32, 32);
        push("t5_rise3", 1'b0, 2'b11, 1'b1, 3, 1'b0, 2'd0, 32, 32);
        push("t5_rise4", 1'b0, 2'b11, 1'b1, 4, 1'b0, 2'd0, 32, 32);
        push("t5_skew", 1'b0, 2'b00, 1'b0, 4, 1'b1, 2'd3, 2, 2);
        push("t5_clear", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            left_lamp = 1'b1; right_lamp = 1'b1; tick(16);
            left_lamp = 1'b0; right_lamp = 1'b0; tick(16);
        end
        left_lamp = 1'b1; tick(16);
        left_lamp = 1'b0; tick(6);
        clear_pulse();
        tick(4);

        // Direction changes, then cross-activation while left is lit.
        push("t6_rise1", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t6_rise2", 1'b0, 2'b01, 1'b1, 2, 1'b0, 2'd0, 32, 32);
        push("t6_rise3", 1'b0, 2'b01, 1'b1, 3, 1'b0, 2'd0, 32, 32);
        push("t6_to_right", 1'b0, 2'b10, 1'b1, 1, 1'b0, 2'd0, 32, 32);
        push("t6_to_left", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 32, 32);
        push("t6_cross", 1'b0, 2'b00, 1'b0, 1, 1'b1, 2'd3, 8, 8);
        push("t6_clear", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            left_lamp = 1'b1; tick(16);
            left_lamp = 1'b0; tick(16);
        end
        right_lamp = 1'b1; tick(16);
        right_lamp = 1'b0; tick(16);
        left_lamp  = 1'b1; tick(8);
        right_lamp = 1'b1; tick(8);
        left_lamp = 1'b0; right_lamp = 1'b0; tick(6);
        clear_pulse();
        tick(4);

        // Clear in the same cycle as a counted rise wins; a later rise starts fresh.
        push("t6_new_seq", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t6_clear_with_rise", 1'b1, 2'b00, 1'b0, 0, 1'b0, 2'd0, 32, 32);
        push("t6_restart", 1'b0, 2'b01, 1'b1, 1, 1'b0, 2'd0, 0, 0);
        push("t6_idle_timeout", 1'b1, 2'b00, 1'b0, 1, 1'b0, 2'd0, 137, 139);
        left_lamp = 1'b1; tick(16);
        left_lamp = 1'b0; tick(16);
        left_lamp = 1'b1; tick(2);
        clear_pulse();
        tick(20);
        left_lamp = 1'b0; tick(10);
        left_lamp = 1'b1; tick(10);
        left_lamp = 1'b0; tick(150);
        tick(10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d expected events never observed, want 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
